// File: rtl/sig_gen_pkg.sv
// rtl/sig_gen_pkg.sv - generator register map and sequencer state encoding
// Purpose: address constants of the tone generator register file and the
//          tone_sequencer FSM states, shared by the sequencer and its users.
// Ports:   none (package).
package sig_gen_pkg;

  localparam logic [2:0] ADDR_PERA = 3'd0;  // channel A period register
  localparam logic [2:0] ADDR_VOLA = 3'd2;  // channel A volume register
  localparam logic [2:0] ADDR_PAT  = 3'd6;  // pattern memory write port (not forwarded)
  localparam logic [2:0] ADDR_CTRL = 3'd7;  // run/loop/last control (not forwarded)

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_PER = 3'd1,
    S_WR_VOL = 3'd2,
    S_WAIT   = 3'd3,
    S_MUTE   = 3'd4
  } state_t;

  // A zero pattern entry is a rest: the period write is skipped and only a
  // zero volume is written for that step.
  function automatic state_t step_entry(input logic [4:0] tone);
    return (tone == 5'd0) ? S_WR_VOL : S_WR_PER;
  endfunction

endpackage

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - host write forwarder and 8-step tone pattern player
// Purpose: forwards host writes to generator registers 0..5 and, when run is
//          set, plays an 8-entry period pattern by writing period/volume
//          registers of channel A once per step.
// Ports:   clk, rst (async, active low)
//          host_we/host_addr/host_data   - host register write port
//          write_strobe/address/data     - registered generator write port
//          busy                          - sequencer not idle
//          step                          - current pattern step index
module tone_sequencer
  import sig_gen_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 1000,
  parameter logic [3:0]  VOL_ON      = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_we,
  input  logic [2:0] host_addr,
  input  logic [4:0] host_data,
  output logic       write_strobe,
  output logic [2:0] address,
  output logic [4:0] data,
  output logic       busy,
  output logic [2:0] step
);

  localparam logic [15:0] CNT_LOAD = 16'(STEP_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_step;
  logic [2:0]  w_step_nxt;
  logic [2:0]  w_step_inc;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;

  logic [4:0]  r_pat [8];
  logic [2:0]  r_wptr;
  logic        r_run;
  logic        r_loop;
  logic [2:0]  r_last;

  logic        r_write_strobe;
  logic [2:0]  r_address;
  logic [4:0]  r_data;

  logic        w_host_fwd;
  logic        w_host_pat;
  logic        w_host_ctrl;
  logic        w_host_stop;
  logic        w_fsm_we;
  logic [2:0]  w_fsm_addr;
  logic [4:0]  w_fsm_data;
  logic        w_clr_run;
  logic [4:0]  w_pat_cur;

  assign w_host_fwd  = host_we && (host_addr < ADDR_PAT);
  assign w_host_pat  = host_we && (host_addr == ADDR_PAT);
  assign w_host_ctrl = host_we && (host_addr == ADDR_CTRL);
  assign w_host_stop = w_host_ctrl && !host_data[0];
  assign w_step_inc  = r_step + 3'd1;
  assign w_pat_cur   = r_pat[r_step];

  assign write_strobe = r_write_strobe;
  assign address      = r_address;
  assign data         = r_data;
  assign busy         = (r_state != S_IDLE);
  assign step         = r_step;

  // Next state. Issuing states only write when the host is not forwarding
  // in the same cycle; otherwise they hold and retry on the next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_cnt_nxt   = r_cnt;
    w_fsm_we    = 1'b0;
    w_fsm_addr  = ADDR_PERA;
    w_fsm_data  = 5'd0;
    w_clr_run   = 1'b0;

    if ((r_state != S_IDLE) && w_host_stop) begin
      // Stop while busy: whatever this state would have written is dropped.
      w_state_nxt = S_MUTE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_run && !w_host_stop) begin
            w_step_nxt  = 3'd0;
            w_state_nxt = step_entry(r_pat[0]);
          end
        end
        S_WR_PER: begin
          if (!w_host_fwd) begin
            w_fsm_we    = 1'b1;
            w_fsm_addr  = ADDR_PERA;
            w_fsm_data  = w_pat_cur;
            w_state_nxt = S_WR_VOL;
          end
        end
        S_WR_VOL: begin
          if (!w_host_fwd) begin
            w_fsm_we    = 1'b1;
            w_fsm_addr  = ADDR_VOLA;
            w_fsm_data  = (w_pat_cur == 5'd0) ? 5'd0 : {1'b0, VOL_ON};
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 16'd0) begin
            w_cnt_nxt = r_cnt - 16'd1;
          end else if (r_step != r_last) begin
            w_step_nxt  = w_step_inc;
            w_state_nxt = step_entry(r_pat[w_step_inc]);
          end else if (r_loop) begin
            w_step_nxt  = 3'd0;
            w_state_nxt = step_entry(r_pat[0]);
          end else begin
            w_clr_run   = 1'b1;
            w_state_nxt = S_MUTE;
          end
        end
        S_MUTE: begin
          if (!w_host_fwd) begin
            w_fsm_we    = 1'b1;
            w_fsm_addr  = ADDR_VOLA;
            w_fsm_data  = 5'd0;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_step  <= 3'd0;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Pattern memory and control register. A control write overrides the
  // sequencer's own end-of-pattern run clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run  <= 1'b0;
      r_loop <= 1'b0;
      r_last <= 3'd0;
      r_wptr <= 3'd0;
      for (int i = 0; i < 8; i++) r_pat[i] <= 5'd0;
    end else begin
      if (w_host_pat) begin
        r_pat[r_wptr] <= host_data;
        r_wptr        <= r_wptr + 3'd1;
      end
      if (w_host_ctrl) begin
        r_run  <= host_data[0];
        r_loop <= host_data[1];
        r_last <= host_data[4:2];
        r_wptr <= 3'd0;
      end else if (w_clr_run) begin
        r_run <= 1'b0;
      end
    end
  end

  // Generator write port; address/data hold their last value between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write_strobe <= 1'b0;
      r_address      <= 3'd0;
      r_data         <= 5'd0;
    end else if (w_host_fwd) begin
      r_write_strobe <= 1'b1;
      r_address      <= host_addr;
      r_data         <= host_data;
    end else if (w_fsm_we) begin
      r_write_strobe <= 1'b1;
      r_address      <= w_fsm_addr;
      r_data         <= w_fsm_data;
    end else begin
      r_write_strobe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - self-checking bench for tone_sequencer
module tb_tone_sequencer;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       host_we = 1'b0;
  logic [2:0] host_addr = 3'd0;
  logic [4:0] host_data = 5'd0;
  logic       write_strobe;
  logic       busy;
  logic [2:0] address;
  logic [2:0] step;
  logic [4:0] data;

  tone_sequencer #(.STEP_CYCLES(S), .VOL_ON(4'd8)) dut (
    .clk(clk), .rst(rst), .host_we(host_we), .host_addr(host_addr),
    .host_data(host_data), .write_strobe(write_strobe), .address(address),
    .data(data), .busy(busy), .step(step)
  );

  always #5 clk = ~clk;

  typedef struct { int c; logic [2:0] a; logic [4:0] d; logic [2:0] s; } wr_t;
  typedef struct { logic [2:0] a; logic [4:0] d; logic exp_s; logic [2:0] exp_a; logic [4:0] exp_d; } fwd_vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  wr_t        log_q[$];
  logic [4:0] m_pat [8];
  fwd_vec_t   tbl [8];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (write_strobe === 1'b1) log_q.push_back('{cyc, address, data, step});

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [4:0] d);
    tick();
    host_we = 1'b1; host_addr = a; host_data = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic wait_busy(input string name, input logic val, input int max);
    int n;
    n = 0;
    while (busy !== val && n < max) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'(val));
  endtask

  // Expected write list from the pattern rules: each step is a period write
  // (unless rest) followed next cycle by a volume write, then STEP_CYCLES
  // cycles of waiting before the next step's first write; a final mute.
  task automatic run_check(input string tag, input bit load, input int last);
    wr_t exp_q[$];
    int  c0;
    int  prev;
    if (load) begin
      host_write(3'd7, 5'd0);
      for (int i = 0; i < 8; i++) host_write(3'd6, m_pat[i]);
    end
    for (int s = 0; s <= last; s++) begin
      if (m_pat[s] != 5'd0) begin
        exp_q.push_back('{(s == 0) ? 2 : S + 1, 3'd0, m_pat[s], 3'(s)});
        exp_q.push_back('{1, 3'd2, 5'd8, 3'(s)});
      end else begin
        exp_q.push_back('{(s == 0) ? 2 : S + 1, 3'd2, 5'd0, 3'(s)});
      end
    end
    exp_q.push_back('{S + 1, 3'd2, 5'd0, 3'(last)});
    log_q.delete();
    host_write(3'd7, {3'(last), 1'b0, 1'b1});
    c0 = cyc;
    wait_busy({tag, " busy_rise"}, 1'b1, 5);
    wait_busy({tag, " busy_fall"}, 1'b0, 500);
    repeat (3) tick();
    check({tag, " write_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      prev = (i == 0) ? c0 : log_q[i-1].c;
      check($sformatf("%s[%0d] address", tag, i), 32'(log_q[i].a), 32'(exp_q[i].a));
      check($sformatf("%s[%0d] data", tag, i), 32'(log_q[i].d), 32'(exp_q[i].d));
      check($sformatf("%s[%0d] step", tag, i), 32'(log_q[i].s), 32'(exp_q[i].s));
      check($sformatf("%s[%0d] gap", tag, i), 32'(log_q[i].c - prev), 32'(exp_q[i].c));
    end
  endtask

  initial begin
    int n;
    int per_cnt;
    int busy_low;
    int per_seen;
    int exp_steps [4];

    // reset state
    repeat (2) tick();
    check("rst strobe", 32'(write_strobe), 32'd0);
    check("rst address", 32'(address), 32'd0);
    check("rst data", 32'(data), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst step", 32'(step), 32'd0);
    rst = 1'b1;
    tick();

    // forwarding table
    tbl[0] = '{3'd1, 5'h0A, 1'b1, 3'd1, 5'h0A};
    tbl[1] = '{3'd0, 5'h1F, 1'b1, 3'd0, 5'h1F};
    tbl[2] = '{3'd5, 5'h11, 1'b1, 3'd5, 5'h11};
    tbl[3] = '{3'd3, 5'h00, 1'b1, 3'd3, 5'h00};
    tbl[4] = '{3'd6, 5'h05, 1'b0, 3'd0, 5'h00};
    tbl[5] = '{3'd7, 5'h1C, 1'b0, 3'd0, 5'h00};
    tbl[6] = '{3'd2, 5'h15, 1'b1, 3'd2, 5'h15};
    tbl[7] = '{3'd4, 5'h0C, 1'b1, 3'd4, 5'h0C};
    for (int i = 0; i < 8; i++) begin
      host_write(tbl[i].a, tbl[i].d);
      check($sformatf("fwd%0d strobe", i), 32'(write_strobe), 32'(tbl[i].exp_s));
      if (tbl[i].exp_s) begin
        check($sformatf("fwd%0d address", i), 32'(address), 32'(tbl[i].exp_a));
        check($sformatf("fwd%0d data", i), 32'(data), 32'(tbl[i].exp_d));
      end
      tick();
      check($sformatf("fwd%0d one_cycle", i), 32'(write_strobe), 32'd0);
    end

    // pattern {3,0,7}, last=2, no loop
    for (int i = 0; i < 8; i++) m_pat[i] = 5'd0;
    m_pat[0] = 5'd3; m_pat[2] = 5'd7;
    run_check("seq370", 1'b1, 2);

    // loop with last=1: steps 0,1,0,1 while busy stays high
    host_write(3'd7, 5'd0);
    host_write(3'd6, 5'd5);
    host_write(3'd6, 5'd9);
    log_q.delete();
    host_write(3'd7, {3'd1, 1'b1, 1'b1});
    wait_busy("loop busy_rise", 1'b1, 5);
    n = 0; per_cnt = 0; busy_low = 0;
    while (per_cnt < 4 && n < 300) begin
      tick();
      n++;
      if (busy !== 1'b1) busy_low = 1;
      per_cnt = 0;
      foreach (log_q[j]) if (log_q[j].a == 3'd0) per_cnt++;
    end
    check("loop per_count", 32'(per_cnt), 32'd4);
    check("loop busy_held", 32'(busy_low), 32'd0);
    exp_steps = '{0, 1, 0, 1};
    per_seen = 0;
    foreach (log_q[j]) begin
      if (log_q[j].a == 3'd0 && per_seen < 4) begin
        check($sformatf("loop per%0d step", per_seen), 32'(log_q[j].s), 32'(exp_steps[per_seen]));
        per_seen++;
      end
    end
    host_write(3'd7, 5'd0);
    log_q.delete();
    wait_busy("loop stop_idle", 1'b0, 4);
    repeat (3) tick();
    check("loop mute_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) begin
      check("loop mute_address", 32'(log_q[0].a), 32'd2);
      check("loop mute_data", 32'(log_q[0].d), 32'd0);
    end

    // host write colliding with pending WR_PER
    host_write(3'd7, 5'd0);
    host_write(3'd6, 5'd3);
    log_q.delete();
    host_write(3'd7, {3'd0, 1'b0, 1'b1});
    host_write(3'd3, 5'h11);
    wait_busy("coll busy_fall", 1'b0, 100);
    repeat (3) tick();
    check("coll write_count", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) begin
      check("coll host_addr", 32'(log_q[0].a), 32'd3);
      check("coll host_data", 32'(log_q[0].d), 32'h11);
      check("coll per_addr", 32'(log_q[1].a), 32'd0);
      check("coll per_data", 32'(log_q[1].d), 32'd3);
      check("coll per_gap", 32'(log_q[1].c - log_q[0].c), 32'd1);
      check("coll vol_gap", 32'(log_q[2].c - log_q[1].c), 32'd1);
      check("coll vol_data", 32'(log_q[2].d), 32'd8);
      check("coll mute_gap", 32'(log_q[3].c - log_q[2].c), 32'(S + 1));
    end

    // run cleared during WAIT of step 1
    host_write(3'd7, 5'd0);
    host_write(3'd6, 5'd4);
    host_write(3'd6, 5'd6);
    log_q.delete();
    host_write(3'd7, {3'd3, 1'b0, 1'b1});
    n = 0; per_seen = 0;
    while (per_seen == 0 && n < 100) begin
      tick();
      n++;
      foreach (log_q[j]) if (log_q[j].a == 3'd2 && log_q[j].s == 3'd1) per_seen = 1;
    end
    check("stop step1_vol_seen", 32'(per_seen), 32'd1);
    host_write(3'd7, 5'd0);
    check("stop mute_state_busy", 32'(busy), 32'd1);
    check("stop no_strobe_yet", 32'(write_strobe), 32'd0);
    log_q.delete();
    tick();
    check("stop mute_strobe", 32'(write_strobe), 32'd1);
    check("stop mute_address", 32'(address), 32'd2);
    check("stop mute_data", 32'(data), 32'd0);
    check("stop idle", 32'(busy), 32'd0);
    repeat (3) tick();
    check("stop single_mute", 32'(log_q.size()), 32'd1);
    check("stop step_held", 32'(step), 32'd1);

    // reset in the middle of WR_VOL
    host_write(3'd7, 5'd0);
    host_write(3'd6, 5'd5);
    host_write(3'd7, {3'd0, 1'b0, 1'b1});
    tick();
    tick();
    check("rst_mid per_strobe", 32'(write_strobe), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rst_mid strobe", 32'(write_strobe), 32'd0);
    check("rst_mid address", 32'(address), 32'd0);
    check("rst_mid data", 32'(data), 32'd0);
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid step", 32'(step), 32'd0);
    log_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    repeat (20) tick();
    check("rst_mid no_strobes", 32'(log_q.size()), 32'd0);
    for (int i = 0; i < 8; i++) m_pat[i] = 5'd0;
    run_check("rst_pat_zero", 1'b0, 7);

    // randomized patterns against the model
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 8; i++)
        m_pat[i] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_check($sformatf("rnd%0d", t), 1'b1, int'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
